// File: rtl/load_use_stall_ctrl_if.sv
// ID-stage hazard bundle: pipeline status into the controller, stall/flush controls out.
// Latency: wires only, no storage.
// Backpressure: none here; stall semantics live in load_use_stall_ctrl.
interface load_use_stall_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  // pipeline status seen by the hazard controller
  logic                  MEM_is_branch_i;
  logic                  EX_DM_read_i;
  logic [REG_ADDR_W-1:0] EX_RD_i;
  logic [REG_ADDR_W-1:0] ID_RS_i;
  logic [REG_ADDR_W-1:0] ID_RT_i;
  logic                  ID_use_rs_i;
  logic                  ID_use_rt_i;
  logic                  MEM_DM_read_i;
  logic                  MEM_dm_ready_i;
  // controls returned to the pipeline
  logic                  PC_stall_o;
  logic                  IF_ID_stall_o;
  logic                  ID_EX_flush_o;
  logic                  ID_EX_stall_o;
  logic                  EX_MEM_stall_o;
  logic [CNT_W-1:0]      stall_cycles_o;

  // pipeline side: supplies status, consumes controls
  modport master (
    output MEM_is_branch_i, EX_DM_read_i, EX_RD_i, ID_RS_i, ID_RT_i,
           ID_use_rs_i, ID_use_rt_i, MEM_DM_read_i, MEM_dm_ready_i,
    input  PC_stall_o, IF_ID_stall_o, ID_EX_flush_o, ID_EX_stall_o,
           EX_MEM_stall_o, stall_cycles_o
  );

  // controller side
  modport slave (
    input  MEM_is_branch_i, EX_DM_read_i, EX_RD_i, ID_RS_i, ID_RT_i,
           ID_use_rs_i, ID_use_rt_i, MEM_DM_read_i, MEM_dm_ready_i,
    output PC_stall_o, IF_ID_stall_o, ID_EX_flush_o, ID_EX_stall_o,
           EX_MEM_stall_o, stall_cycles_o
  );
endinterface

// File: rtl/load_use_stall_ctrl.sv
// Multi-bubble load-use hazard controller with memory-wait freeze and stall-cycle counter.
// Latency: stall/flush outputs are combinational in the hit cycle; counter updates on the next edge.
// Backpressure: a pending data-memory load freezes PC through EX/MEM and holds the bubble FSM.
module load_use_stall_ctrl #(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1,  // 1..7; cnt is 3 bits
  parameter int IGNORE_R0         = 1,
  parameter int CNT_W             = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  load_use_stall_ctrl_if.slave hz
);

  typedef enum logic {IDLE, LU_STALL} state_t;

  localparam logic [2:0]       BUBBLES_LEFT = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  state_t           state_q, state_nxt;
  logic [2:0]       cnt_q, cnt_nxt;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             hit;
  logic             mem_wait;
  logic             pc_stall;
  logic             flush;
  logic             mem_stall;

  // load in EX feeds a source the ID instruction actually reads ($zero excluded if enabled)
  always_comb begin
    hit = hz.EX_DM_read_i
        & ((hz.ID_use_rs_i & (hz.ID_RS_i == hz.EX_RD_i)) |
           (hz.ID_use_rt_i & (hz.ID_RT_i == hz.EX_RD_i)))
        & ~((IGNORE_R0 != 0) & (hz.EX_RD_i == '0));
    mem_wait = hz.MEM_DM_read_i & ~hz.MEM_dm_ready_i;
  end

  // next-state and controls; priority branch > mem_wait > ongoing bubbles > new hit
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    pc_stall  = 1'b0;
    flush     = 1'b0;
    mem_stall = 1'b0;
    if (!rst_i) begin
      // controls held low for as long as reset is asserted
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (hz.MEM_is_branch_i) begin
      // flush wins, including over a branch+load conflict; abandon any remaining bubbles
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (mem_wait) begin
      pc_stall  = 1'b1;
      mem_stall = 1'b1;
    end else if (state_q == LU_STALL) begin
      pc_stall = 1'b1;
      flush    = 1'b1;
      if (cnt_q == 3'd1) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt_q - 3'd1;
      end
    end else if (hit) begin
      pc_stall = 1'b1;
      flush    = 1'b1;
      if (LOAD_STALL_CYCLES > 1) begin
        state_nxt = LU_STALL;
        cnt_nxt   = BUBBLES_LEFT;
      end
    end
  end

  // FSM and remaining-bubble register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // saturating count of cycles with the PC held
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else if (pc_stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign hz.PC_stall_o     = pc_stall;
  assign hz.IF_ID_stall_o  = pc_stall;
  assign hz.ID_EX_flush_o  = flush;
  assign hz.ID_EX_stall_o  = mem_stall;
  assign hz.EX_MEM_stall_o = mem_stall;
  assign hz.stall_cycles_o = stall_cnt_q;

endmodule

// File: tb/tb_load_use_stall_ctrl.sv
// Bench for load_use_stall_ctrl: three configurations share one stimulus stream.
// Latency: outputs sampled 1 time unit after inputs change at the falling edge.
// Backpressure: data-memory wait exercised through MEM_DM_read_i/MEM_dm_ready_i.
module tb_load_use_stall_ctrl;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // shared stimulus
  logic       br, ld, urs, urt, mld, rdy;
  logic [4:0] rd, rs, rt;

  // a: LSC=1  b: LSC=3  c: LSC=3 with a 2-bit counter
  load_use_stall_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) if_a ();
  load_use_stall_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) if_b ();
  load_use_stall_ctrl_if #(.REG_ADDR_W(5), .CNT_W(2))  if_c ();

  assign if_a.MEM_is_branch_i = br;  assign if_b.MEM_is_branch_i = br;  assign if_c.MEM_is_branch_i = br;
  assign if_a.EX_DM_read_i    = ld;  assign if_b.EX_DM_read_i    = ld;  assign if_c.EX_DM_read_i    = ld;
  assign if_a.EX_RD_i         = rd;  assign if_b.EX_RD_i         = rd;  assign if_c.EX_RD_i         = rd;
  assign if_a.ID_RS_i         = rs;  assign if_b.ID_RS_i         = rs;  assign if_c.ID_RS_i         = rs;
  assign if_a.ID_RT_i         = rt;  assign if_b.ID_RT_i         = rt;  assign if_c.ID_RT_i         = rt;
  assign if_a.ID_use_rs_i     = urs; assign if_b.ID_use_rs_i     = urs; assign if_c.ID_use_rs_i     = urs;
  assign if_a.ID_use_rt_i     = urt; assign if_b.ID_use_rt_i     = urt; assign if_c.ID_use_rt_i     = urt;
  assign if_a.MEM_DM_read_i   = mld; assign if_b.MEM_DM_read_i   = mld; assign if_c.MEM_DM_read_i   = mld;
  assign if_a.MEM_dm_ready_i  = rdy; assign if_b.MEM_dm_ready_i  = rdy; assign if_c.MEM_dm_ready_i  = rdy;

  load_use_stall_ctrl #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1), .IGNORE_R0(1), .CNT_W(16))
    dut_a (.clk_i(clk_i), .rst_i(rst_i), .hz(if_a));
  load_use_stall_ctrl #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3), .IGNORE_R0(1), .CNT_W(16))
    dut_b (.clk_i(clk_i), .rst_i(rst_i), .hz(if_b));
  load_use_stall_ctrl #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3), .IGNORE_R0(1), .CNT_W(2))
    dut_c (.clk_i(clk_i), .rst_i(rst_i), .hz(if_c));

  typedef struct {
    int         sel;     // which DUT is checked
    bit         rb;      // pulse reset before this vector
    logic       br, ld, urs, urt, mld, rdy;
    logic [4:0] rd, rs, rt;
    logic       pc, fl, ms;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    int          sel;
    int          idx;
    logic        pc, fl, ms;
    logic [15:0] cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(int sel, bit rb, bit b, bit l, int d, int s, int t,
                              bit us, bit ut, bit ml, bit ry,
                              bit pc, bit fl, bit ms, int cnt);
    vec_t v;
    v.sel = sel; v.rb = rb; v.br = b; v.ld = l;
    v.rd = 5'(d); v.rs = 5'(s); v.rt = 5'(t);
    v.urs = us; v.urt = ut; v.mld = ml; v.rdy = ry;
    v.pc = pc; v.fl = fl; v.ms = ms; v.cnt = 16'(cnt);
    return v;
  endfunction

  task automatic check(string name, int idx, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    br = v.br; ld = v.ld; rd = v.rd; rs = v.rs; rt = v.rt;
    urs = v.urs; urt = v.urt; mld = v.mld; rdy = v.rdy;
  endtask

  task automatic idle_inputs();
    br = 0; ld = 0; rd = 0; rs = 0; rt = 0; urs = 0; urt = 0; mld = 0; rdy = 1;
  endtask

  task automatic pulse_reset();
    @(negedge clk_i);
    idle_inputs();
    rst_i = 1'b0;
    #2;
    rst_i = 1'b1;
  endtask

  task automatic compare(exp_t e);
    logic        pc, ifid, fl, ms, exm;
    logic [15:0] cnt;
    case (e.sel)
      0: begin pc = if_a.PC_stall_o; ifid = if_a.IF_ID_stall_o; fl = if_a.ID_EX_flush_o;
               ms = if_a.ID_EX_stall_o; exm = if_a.EX_MEM_stall_o; cnt = if_a.stall_cycles_o; end
      1: begin pc = if_b.PC_stall_o; ifid = if_b.IF_ID_stall_o; fl = if_b.ID_EX_flush_o;
               ms = if_b.ID_EX_stall_o; exm = if_b.EX_MEM_stall_o; cnt = if_b.stall_cycles_o; end
      default: begin pc = if_c.PC_stall_o; ifid = if_c.IF_ID_stall_o; fl = if_c.ID_EX_flush_o;
               ms = if_c.ID_EX_stall_o; exm = if_c.EX_MEM_stall_o; cnt = 16'(if_c.stall_cycles_o); end
    endcase
    check("pc_stall",    e.idx, 16'(pc),   16'(e.pc));
    check("if_id_stall", e.idx, 16'(ifid), 16'(e.pc));
    check("id_ex_flush", e.idx, 16'(fl),   16'(e.fl));
    check("id_ex_stall", e.idx, 16'(ms),   16'(e.ms));
    check("ex_mem_stall",e.idx, 16'(exm),  16'(e.ms));
    check("stall_cycles",e.idx, cnt,       e.cnt);
  endtask

  initial begin
    exp_t e;
    idle_inputs();

    // ----- vector table: sel rb br ld rd rs rt urs urt mld rdy | pc fl ms cnt
    // LSC=1: single bubble on rs match, then quiet
    vecs.push_back(mk(0,1, 0,1, 8,8,0, 1,0, 0,1, 1,1,0, 0));
    vecs.push_back(mk(0,0, 0,0, 0,0,0, 0,0, 0,1, 0,0,0, 1));
    // $zero destination and unused source never stall
    vecs.push_back(mk(0,0, 0,1, 0,0,0, 1,1, 0,1, 0,0,0, 1));
    vecs.push_back(mk(0,0, 0,1, 8,8,3, 0,1, 0,1, 0,0,0, 1));
    // rt match stalls
    vecs.push_back(mk(0,0, 0,1, 9,2,9, 0,1, 0,1, 1,1,0, 1));
    vecs.push_back(mk(0,0, 0,0, 0,0,0, 0,0, 0,1, 0,0,0, 2));
    // memory wait in IDLE, then ready load
    vecs.push_back(mk(0,0, 0,0, 0,0,0, 0,0, 1,0, 1,0,1, 2));
    vecs.push_back(mk(0,0, 0,0, 0,0,0, 0,0, 1,1, 0,0,0, 3));
    // branch beats a simultaneous hit and a simultaneous branch+load
    vecs.push_back(mk(0,0, 1,1, 8,8,0, 1,0, 0,1, 0,0,0, 3));
    vecs.push_back(mk(0,0, 1,0, 0,0,0, 0,0, 1,0, 0,0,0, 3));
    // LSC=3: rt hit gives exactly three bubbles; hit held during LU_STALL changes nothing
    vecs.push_back(mk(1,1, 0,1, 5,0,5, 0,1, 0,1, 1,1,0, 0));
    vecs.push_back(mk(1,0, 0,1, 5,0,5, 0,1, 0,1, 1,1,0, 1));
    vecs.push_back(mk(1,0, 0,1, 5,0,5, 0,1, 0,1, 1,1,0, 2));
    vecs.push_back(mk(1,0, 0,0, 0,0,0, 0,0, 0,1, 0,0,0, 3));
    // LSC=3: branch on second bubble cancels the third
    vecs.push_back(mk(1,1, 0,1, 7,7,0, 1,0, 0,1, 1,1,0, 0));
    vecs.push_back(mk(1,0, 1,0, 0,0,0, 0,0, 0,1, 0,0,0, 1));
    vecs.push_back(mk(1,0, 0,0, 0,0,0, 0,0, 0,1, 0,0,0, 1));
    vecs.push_back(mk(1,0, 0,0, 0,0,0, 0,0, 0,1, 0,0,0, 1));
    // LSC=3: four memory-wait cycles with two bubbles pending, then two bubbles
    vecs.push_back(mk(1,1, 0,1, 4,4,0, 1,0, 0,1, 1,1,0, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1,0, 0,0, 0,0,0, 0,0, 1,0, 1,0,1, 1+i));
    vecs.push_back(mk(1,0, 0,0, 0,0,0, 0,0, 1,1, 1,1,0, 5));
    vecs.push_back(mk(1,0, 0,0, 0,0,0, 0,0, 0,1, 1,1,0, 6));
    vecs.push_back(mk(1,0, 0,0, 0,0,0, 0,0, 0,1, 0,0,0, 7));
    // CNT_W=2: six stall cycles, counter pinned at 3
    vecs.push_back(mk(2,1, 0,1, 6,6,0, 1,0, 0,1, 1,1,0, 0));
    vecs.push_back(mk(2,0, 0,0, 0,0,0, 0,0, 0,1, 1,1,0, 1));
    vecs.push_back(mk(2,0, 0,0, 0,0,0, 0,0, 0,1, 1,1,0, 2));
    vecs.push_back(mk(2,0, 0,1, 6,0,6, 0,1, 0,1, 1,1,0, 3));
    vecs.push_back(mk(2,0, 0,0, 0,0,0, 0,0, 0,1, 1,1,0, 3));
    vecs.push_back(mk(2,0, 0,0, 0,0,0, 0,0, 0,1, 1,1,0, 3));
    vecs.push_back(mk(2,0, 0,0, 0,0,0, 0,0, 0,1, 0,0,0, 3));

    // ----- reset held with a live hit: every control stays low
    #3;
    ld = 1; rd = 8; rs = 8; urs = 1;
    #1;
    for (int s = 0; s < 3; s++) begin
      e.sel = s; e.idx = -1; e.pc = 0; e.fl = 0; e.ms = 0; e.cnt = 0;
      sb.push_back(e);
      compare(sb.pop_front());
    end
    idle_inputs();
    @(negedge clk_i);
    rst_i = 1'b1;

    // ----- table-driven run through the scoreboard
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rb) pulse_reset();
      @(negedge clk_i);
      apply(vecs[i]);
      e.sel = vecs[i].sel; e.idx = i;
      e.pc = vecs[i].pc; e.fl = vecs[i].fl; e.ms = vecs[i].ms; e.cnt = vecs[i].cnt;
      sb.push_back(e);
      #1;
      compare(sb.pop_front());
    end

    // ----- asynchronous reset in the middle of a multi-bubble stall
    pulse_reset();
    @(negedge clk_i);
    ld = 1; rd = 10; rs = 10; urs = 1;
    @(negedge clk_i);
    idle_inputs();
    #1;
    check("mid_stall_pc_before_rst", 100, 16'(if_c.PC_stall_o), 16'd1);
    check("mid_stall_cnt_before_rst", 100, 16'(if_c.stall_cycles_o), 16'd1);
    rst_i = 1'b0;
    #1;
    check("async_rst_pc",    101, 16'(if_c.PC_stall_o),     16'd0);
    check("async_rst_flush", 101, 16'(if_c.ID_EX_flush_o),  16'd0);
    check("async_rst_cnt",   101, 16'(if_c.stall_cycles_o), 16'd0);
    check("async_rst_cnt_b", 101, if_b.stall_cycles_o,      16'd0);
    rst_i = 1'b1;
    @(negedge clk_i);
    #1;
    check("post_rst_idle_pc", 102, 16'(if_b.PC_stall_o), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
